// File: rtl/line_buf_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : line_buf_seq_if
// Purpose  : Bundles the mode/strobe inputs and the buffer-control outputs
//            of the line-buffer sequencer.
// Ports    : i_mode[1:0]      requested mode (00 LOAD, 01 PROC, 10 OUT, 11 HOLD)
//            i_chblk          block-change strobe (rising edges act)
//            o_state[1:0]     registered mode
//            o_we[NBUF-1:0]   per-buffer write/read enable
//            o_memSelect      buffer index for the LOAD/OUT mux
//            o_base           PROC window base index
//            o_substate       OUT addressing substate
//            o_ld_wrap        one-cycle pulse on load-pointer wrap
//            o_wrap_cnt[15:0] load-wrap counter
// Modports : master (stimulus side), slave (sequencer side)
// Revision : 1.0 - initial release
// ============================================================================
interface line_buf_seq_if #(
  parameter int NBUF = 5,
  parameter int NSUB = 2
);
  localparam int SEL_W = $clog2(NBUF);
  localparam int SUB_W = (NSUB > 1) ? $clog2(NSUB) : 1;

  logic [1:0]       i_mode;
  logic             i_chblk;
  logic [1:0]       o_state;
  logic [NBUF-1:0]  o_we;
  logic [SEL_W-1:0] o_memSelect;
  logic [SEL_W-1:0] o_base;
  logic [SUB_W-1:0] o_substate;
  logic             o_ld_wrap;
  logic [15:0]      o_wrap_cnt;

  modport master (
    output i_mode, i_chblk,
    input  o_state, o_we, o_memSelect, o_base, o_substate, o_ld_wrap, o_wrap_cnt
  );

  modport slave (
    input  i_mode, i_chblk,
    output o_state, o_we, o_memSelect, o_base, o_substate, o_ld_wrap, o_wrap_cnt
  );
endinterface
`default_nettype wire

// File: rtl/line_buf_seq.sv
`default_nettype none
// ============================================================================
// Module   : line_buf_seq
// Purpose  : Sequencer for a ring of NBUF = N+NEXTRA line buffers. LOAD
//            writes one buffer at a time, PROC enables an N-buffer window
//            that slides by STEP, OUT reads buffers out one by one, HOLD
//            freezes everything. Pointers advance on rising edges of
//            i_chblk, interpreted in the registered mode.
// Ports    : clk   clock, rising edge
//            rst   synchronous active-high reset
//            bus   line_buf_seq_if.slave (mode/strobe in, controls out)
// Macro    : LINE_BUF_SEQ_WRAP_CNT_EN - when defined, o_wrap_cnt counts
//            load-pointer wraps (mod 2^16); otherwise it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module line_buf_seq #(
  parameter int N      = 3,
  parameter int NEXTRA = 2,
  parameter int STEP   = 1,
  parameter int NSUB   = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  line_buf_seq_if.slave bus
);
  localparam int NBUF  = N + NEXTRA;
  localparam int SEL_W = $clog2(NBUF);
  localparam int SUB_W = (NSUB > 1) ? $clog2(NSUB) : 1;

  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NBUF - 1);
  localparam logic [SEL_W-1:0] BASE_LIM = SEL_W'(NBUF - STEP);
  localparam logic [SEL_W-1:0] STEP_V   = SEL_W'(STEP);
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(NSUB - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_PROC = 2'b01,
    ST_OUT  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  state_t           state_q;
  logic             chblk_q;
  logic [SEL_W-1:0] ld_ptr_q;
  logic [SEL_W-1:0] base_q;
  logic [SEL_W-1:0] out_ptr_q;
  logic [SUB_W-1:0] sub_q;
  logic             ld_wrap_q;

  logic             blk_edge;
  logic [SEL_W-1:0] ld_ptr_d;
  logic [SEL_W-1:0] base_d;
  logic [SEL_W-1:0] out_ptr_d;
  logic [SUB_W-1:0] sub_d;
  logic             out_entry;
  logic [NBUF-1:0]  we;
  logic [SEL_W-1:0] mem_sel;

  assign blk_edge  = bus.i_chblk & ~chblk_q;

  assign ld_ptr_d  = (ld_ptr_q  == SEL_MAX) ? '0 : ld_ptr_q  + 1'b1;
  assign out_ptr_d = (out_ptr_q == SEL_MAX) ? '0 : out_ptr_q + 1'b1;
  assign sub_d     = (sub_q     == SUB_MAX) ? '0 : sub_q     + 1'b1;
  // Subtract the complement instead of adding STEP then reducing, so the
  // intermediate never exceeds NBUF-1 and cannot overflow SEL_W bits.
  assign base_d    = (base_q >= BASE_LIM) ? (base_q - BASE_LIM) : (base_q + STEP_V);

  // Substate bumps once per OUT entry; HOLD keeps it frozen even if the
  // next requested mode is OUT.
  assign out_entry = (state_q != ST_OUT) && (state_q != ST_HOLD) &&
                     (bus.i_mode == 2'(ST_OUT));

  // N consecutive ones starting at bit b, wrapping from bit NBUF-1 to bit 0.
  function automatic logic [NBUF-1:0] proc_mask(input logic [SEL_W-1:0] b);
    logic [NBUF-1:0] m;
    int              off;
    m = '0;
    for (int i = 0; i < NBUF; i++) begin
      off = (i >= int'(b)) ? (i - int'(b)) : (i + NBUF - int'(b));
      if (off < N) m[i] = 1'b1;
    end
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      chblk_q   <= 1'b0;
      ld_ptr_q  <= '0;
      base_q    <= '0;
      out_ptr_q <= '0;
      sub_q     <= '0;
      ld_wrap_q <= 1'b0;
    end else begin
      state_q   <= state_t'(bus.i_mode);
      chblk_q   <= bus.i_chblk;
      ld_wrap_q <= 1'b0;
      // The edge is steered by the mode already registered, not by i_mode.
      if (blk_edge) begin
        case (state_q)
          ST_LOAD: begin
            ld_ptr_q  <= ld_ptr_d;
            ld_wrap_q <= (ld_ptr_q == SEL_MAX);
          end
          ST_PROC: base_q    <= base_d;
          ST_OUT:  out_ptr_q <= out_ptr_d;
          default: ;
        endcase
      end
      if (out_entry) sub_q <= sub_d;
    end
  end

  always_comb begin
    we      = '0;
    mem_sel = '0;
    case (state_q)
      ST_LOAD: begin
        we[ld_ptr_q] = 1'b1;
        mem_sel      = ld_ptr_q;
      end
      ST_PROC: we      = proc_mask(base_q);
      ST_OUT:  mem_sel = out_ptr_q;
      default: ;
    endcase
  end

`ifdef LINE_BUF_SEQ_WRAP_CNT_EN
  logic [15:0] wrap_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt_q <= '0;
    end else if (ld_wrap_q) begin
      wrap_cnt_q <= wrap_cnt_q + 16'd1;
    end
  end

  assign bus.o_wrap_cnt = wrap_cnt_q;
`else
  assign bus.o_wrap_cnt = 16'd0;
`endif

  assign bus.o_state     = state_q;
  assign bus.o_we        = we;
  assign bus.o_memSelect = mem_sel;
  assign bus.o_base      = base_q;
  assign bus.o_substate  = sub_q;
  assign bus.o_ld_wrap   = ld_wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_line_buf_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buf_seq
// Purpose  : Directed self-checking bench for line_buf_seq with N=3,
//            NEXTRA=2 (NBUF=5), STEP=1, NSUB=2. Expected outputs are queued
//            as each step is driven and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buf_seq;
  localparam logic [1:0] L = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] H = 2'b11;

`ifdef LINE_BUF_SEQ_WRAP_CNT_EN
  localparam int WC_ON = 1;
`else
  localparam int WC_ON = 0;
`endif

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] we;
    logic [2:0] sel;
    logic [2:0] base;
    logic [0:0] sub;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t  sb_q[$];
  string tag_q[$];

  line_buf_seq_if #(.NBUF(5), .NSUB(2)) bus ();

  line_buf_seq #(.N(3), .NEXTRA(2), .STEP(1), .NSUB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] st, logic [4:0] we, int sel, int base,
                              int sub, logic wrap);
    exp_t e;
    e.st   = st;
    e.we   = we;
    e.sel  = 3'(sel);
    e.base = 3'(base);
    e.sub  = 1'(sub);
    e.wrap = wrap;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the
  // edge, then pop and compare once the edge has passed.
  task automatic step(string tag, logic [1:0] m, logic cb, logic r, exp_t e);
    exp_t  x;
    string t;
    @(negedge clk);
    rst         = r;
    bus.i_mode  = m;
    bus.i_chblk = cb;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".state"},  32'(bus.o_state),     32'(x.st));
    check({t, ".we"},     32'(bus.o_we),        32'(x.we));
    check({t, ".sel"},    32'(bus.o_memSelect), 32'(x.sel));
    check({t, ".base"},   32'(bus.o_base),      32'(x.base));
    check({t, ".sub"},    32'(bus.o_substate),  32'(x.sub));
    check({t, ".ldwrap"}, 32'(bus.o_ld_wrap),   32'(x.wrap));
  endtask

  initial begin
    logic [4:0] w;
    int         k5;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.i_mode  = L;
    bus.i_chblk = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step("rst", L, 1'b0, 1'b1, mk(L, 5'b00001, 0, 0, 0, 1'b0));
    check("rst.wrapcnt", 32'(bus.o_wrap_cnt), 32'd0);

    // LOAD: five pulses walk the one-hot write enable round the ring;
    // the first pulse lands in the first cycle after reset.
    step("ld1",  L, 1'b1, 1'b0, mk(L, 5'b00010, 1, 0, 0, 1'b0));
    step("ld1z", L, 1'b0, 1'b0, mk(L, 5'b00010, 1, 0, 0, 1'b0));
    step("ld2",  L, 1'b1, 1'b0, mk(L, 5'b00100, 2, 0, 0, 1'b0));
    step("ld2z", L, 1'b0, 1'b0, mk(L, 5'b00100, 2, 0, 0, 1'b0));
    step("ld3",  L, 1'b1, 1'b0, mk(L, 5'b01000, 3, 0, 0, 1'b0));
    step("ld3z", L, 1'b0, 1'b0, mk(L, 5'b01000, 3, 0, 0, 1'b0));
    step("ld4",  L, 1'b1, 1'b0, mk(L, 5'b10000, 4, 0, 0, 1'b0));
    step("ld4z", L, 1'b0, 1'b0, mk(L, 5'b10000, 4, 0, 0, 1'b0));
    step("ld5",  L, 1'b1, 1'b0, mk(L, 5'b00001, 0, 0, 0, 1'b1));
    step("ld5z", L, 1'b0, 1'b0, mk(L, 5'b00001, 0, 0, 0, 1'b0));
    check("ld.wrapcnt1", 32'(bus.o_wrap_cnt), 32'(WC_ON));

    // PROC: the 3-wide window slides and wraps across bit 4 -> bit 0.
    step("pr0",  P, 1'b0, 1'b0, mk(P, 5'b00111, 0, 0, 0, 1'b0));
    step("pr1",  P, 1'b1, 1'b0, mk(P, 5'b01110, 0, 1, 0, 1'b0));
    step("pr1z", P, 1'b0, 1'b0, mk(P, 5'b01110, 0, 1, 0, 1'b0));
    step("pr2",  P, 1'b1, 1'b0, mk(P, 5'b11100, 0, 2, 0, 1'b0));
    step("pr2z", P, 1'b0, 1'b0, mk(P, 5'b11100, 0, 2, 0, 1'b0));
    step("pr3",  P, 1'b1, 1'b0, mk(P, 5'b11001, 0, 3, 0, 1'b0));
    step("pr3z", P, 1'b0, 1'b0, mk(P, 5'b11001, 0, 3, 0, 1'b0));
    step("pr4",  P, 1'b1, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));
    step("pr4z", P, 1'b0, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));

    // Strobe held high across LOAD->PROC: one load advance, base untouched.
    step("hh0", L, 1'b0, 1'b0, mk(L, 5'b00001, 0, 4, 0, 1'b0));
    step("hh1", L, 1'b1, 1'b0, mk(L, 5'b00010, 1, 4, 0, 1'b0));
    step("hh2", P, 1'b1, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));
    step("hh3", P, 1'b1, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));
    step("hh4", P, 1'b0, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));

    // Edge coinciding with a LOAD->PROC request acts in LOAD.
    step("em0", L, 1'b0, 1'b0, mk(L, 5'b00010, 1, 4, 0, 1'b0));
    step("em1", P, 1'b1, 1'b0, mk(P, 5'b10011, 0, 4, 0, 1'b0));
    step("em2", L, 1'b0, 1'b0, mk(L, 5'b00100, 2, 4, 0, 1'b0));

    // OUT entries toggle the substate; out_ptr drives the select.
    step("ot0", O, 1'b0, 1'b0, mk(O, 5'b00000, 0, 4, 1, 1'b0));
    step("ot1", O, 1'b1, 1'b0, mk(O, 5'b00000, 1, 4, 1, 1'b0));
    step("ot2", O, 1'b0, 1'b0, mk(O, 5'b00000, 1, 4, 1, 1'b0));
    step("ot3", L, 1'b0, 1'b0, mk(L, 5'b00100, 2, 4, 1, 1'b0));
    step("ot4", O, 1'b0, 1'b0, mk(O, 5'b00000, 1, 4, 0, 1'b0));
    step("ot5", O, 1'b1, 1'b0, mk(O, 5'b00000, 2, 4, 0, 1'b0));
    step("ot6", O, 1'b0, 1'b0, mk(O, 5'b00000, 2, 4, 0, 1'b0));

    // HOLD ignores strobes.
    step("hd0", H, 1'b0, 1'b0, mk(H, 5'b00000, 0, 4, 0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step("hdp", H, 1'b1, 1'b0, mk(H, 5'b00000, 0, 4, 0, 1'b0));
      step("hdz", H, 1'b0, 1'b0, mk(H, 5'b00000, 0, 4, 0, 1'b0));
    end
    step("hd1", L, 1'b0, 1'b0, mk(L, 5'b00100, 2, 4, 0, 1'b0));
    step("hd2", O, 1'b0, 1'b0, mk(O, 5'b00000, 2, 4, 1, 1'b0));

    // Base wraps 4 -> 0, advances to 1, then reset mid-PROC with a strobe.
    step("bw0", P, 1'b0, 1'b0, mk(P, 5'b10011, 0, 4, 1, 1'b0));
    step("bw1", P, 1'b1, 1'b0, mk(P, 5'b00111, 0, 0, 1, 1'b0));
    step("bw2", P, 1'b0, 1'b0, mk(P, 5'b00111, 0, 0, 1, 1'b0));
    step("bw3", P, 1'b1, 1'b0, mk(P, 5'b01110, 0, 1, 1, 1'b0));
    step("bw4", P, 1'b0, 1'b0, mk(P, 5'b01110, 0, 1, 1, 1'b0));
    step("rs0", P, 1'b1, 1'b1, mk(L, 5'b00001, 0, 0, 0, 1'b0));
    check("rs0.wrapcnt", 32'(bus.o_wrap_cnt), 32'd0);
    step("rs1", L, 1'b1, 1'b0, mk(L, 5'b00010, 1, 0, 0, 1'b0));

    // Ten LOAD pulses from a clean reset give two wraps.
    step("rs2", L, 1'b0, 1'b1, mk(L, 5'b00001, 0, 0, 0, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      k5 = k % 5;
      w  = 5'b00001 << k5;
      step("wc", L, 1'b1, 1'b0, mk(L, w, k5, 0, 0, k5 == 0));
      step("wcz", L, 1'b0, 1'b0, mk(L, w, k5, 0, 0, 1'b0));
    end
    check("wc.final", 32'(bus.o_wrap_cnt), 32'(2 * WC_ON));
    check("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
